// File: rtl/pu_layer_sequencer_if.sv
// Bundle between the layer sequencer, its controller, the weight ROM and the PU.
// The slave modport is the sequencer's view; the master modport is the surrounding environment.
interface pu_layer_sequencer_if #(
    parameter int unsigned size   = 16,
    parameter int unsigned ADDR_W = 12
);
    logic                start;
    logic [8*size-1:0]   x_in;
    logic                busy;
    logic                done;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [size-1:0]     mem_data;
    logic [8*size-1:0]   pu_x;
    logic [8*size-1:0]   pu_w;
    logic [size-1:0]     pu_bias;
    logic [size-1:0]     pu_out;
    logic                res_valid;
    logic [7:0]          res_idx;
    logic [size-1:0]     res_data;

    modport slave (
        input  start, x_in, mem_data, pu_out,
        output busy, done, mem_rd, mem_addr, pu_x, pu_w, pu_bias,
               res_valid, res_idx, res_data
    );

    modport master (
        output start, x_in, mem_data, pu_out,
        input  busy, done, mem_rd, mem_addr, pu_x, pu_w, pu_bias,
               res_valid, res_idx, res_data
    );
endinterface

// File: rtl/pu_layer_sequencer.sv
// Time-multiplexes one 8-input PU across a layer of NUM_NEURONS neurons.
// Optional macro PU_SEQ_RELU_EN applies ReLU to each captured result.
module pu_layer_sequencer #(
    parameter int unsigned size        = 16,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    pu_layer_sequencer_if.slave   bus
);
    localparam logic [7:0] LAST_N = 8'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LAST, EVAL, FIN} state_t;

    state_t                 state;
    logic [7:0]             n;
    logic [3:0]             k;
    logic [7:0][size-1:0]   x_q;
    logic [7:0][size-1:0]   w_q;
    logic [size-1:0]        bias_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   mem_rd_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   res_valid_q;
    logic [7:0]             res_idx_q;
    logic [size-1:0]        res_data_q;
    logic [size-1:0]        act_c;

    // Value captured into res_data during EVAL
`ifdef PU_SEQ_RELU_EN
    assign act_c = bus.pu_out[size-1] ? '0 : bus.pu_out;
`else
    assign act_c = bus.pu_out;
`endif

    // Neuron addresses are contiguous (9n..9n+8), so the read address simply advances
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n           <= '0;
            k           <= '0;
            x_q         <= '0;
            w_q         <= '0;
            bias_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            addr_q      <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q      <= bus.x_in;
                        n        <= '0;
                        k        <= '0;
                        busy_q   <= 1'b1;
                        mem_rd_q <= 1'b1;
                        addr_q   <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (k != 4'd0) begin
                        w_q[3'(k - 4'd1)] <= bus.mem_data;
                    end
                    if (k == 4'd8) begin
                        mem_rd_q <= 1'b0;
                        state    <= LAST;
                    end else begin
                        k      <= k + 4'd1;
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                LAST: begin
                    bias_q <= bus.mem_data;
                    state  <= EVAL;
                end
                EVAL: begin
                    res_data_q  <= act_c;
                    res_idx_q   <= n;
                    res_valid_q <= 1'b1;
                    if (n == LAST_N) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        n        <= n + 8'd1;
                        k        <= '0;
                        mem_rd_q <= 1'b1;
                        addr_q   <= addr_q + ADDR_W'(1);
                        state    <= LOAD;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = addr_q;
    assign bus.pu_x      = x_q;
    assign bus.pu_w      = w_q;
    assign bus.pu_bias   = bias_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Bench for pu_layer_sequencer: two instances (4-neuron and 1-neuron layers) checked every cycle
// against a cycle-offset model of the layer schedule, plus literal checks of directed scenarios.
module tb_pu_layer_sequencer;
    localparam int unsigned SZ = 16;
    localparam int unsigned AW = 12;
    localparam int N0 = 4;
    localparam int N1 = 1;

    typedef struct {
        int              c;
        logic [SZ-1:0]   d;
        logic [7:0]      idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [8*SZ-1:0] x_in;
    always #5 clk = ~clk;

    pu_layer_sequencer_if #(.size(SZ), .ADDR_W(AW)) bus0();
    pu_layer_sequencer_if #(.size(SZ), .ADDR_W(AW)) bus1();

    pu_layer_sequencer #(.size(SZ), .NUM_NEURONS(N0), .ADDR_W(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pu_layer_sequencer #(.size(SZ), .NUM_NEURONS(N1), .ADDR_W(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [SZ-1:0] mem [0:63];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    function automatic logic [SZ-1:0] pu_calc(input logic [8*SZ-1:0] x, input logic [8*SZ-1:0] w,
                                              input logic [SZ-1:0] b);
        logic [SZ-1:0] acc;
        acc = b;
        for (int i = 0; i < 8; i++) acc = acc + SZ'(x[i*SZ +: SZ] * w[i*SZ +: SZ]);
        return acc;
    endfunction

    function automatic logic [8*SZ-1:0] rep(input logic [SZ-1:0] v);
        return {8{v}};
    endfunction

    // Environment: ROM with one-cycle latency and a combinational PU
    assign bus0.start = start;
    assign bus0.x_in  = x_in;
    assign bus1.start = start;
    assign bus1.x_in  = x_in;
    assign bus0.pu_out = pu_calc(bus0.pu_x, bus0.pu_w, bus0.pu_bias);
    assign bus1.pu_out = pu_calc(bus1.pu_x, bus1.pu_w, bus1.pu_bias);
    always @(posedge clk) begin
        if (rst) bus0.mem_data <= '0;
        else if (bus0.mem_rd) bus0.mem_data <= mem[bus0.mem_addr[5:0]];
        if (rst) bus1.mem_data <= '0;
        else if (bus1.mem_rd) bus1.mem_data <= mem[bus1.mem_addr[5:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: neuron n result from the spec arithmetic on the latched vector
    function automatic logic [SZ-1:0] ref_res(input logic [8*SZ-1:0] x, input int n);
        logic [8*SZ-1:0] w;
        logic [SZ-1:0]   r;
        for (int k = 0; k < 8; k++) w[k*SZ +: SZ] = mem[9*n + k];
        r = pu_calc(x, w, mem[9*n + 8]);
`ifdef PU_SEQ_RELU_EN
        if (r[SZ-1]) r = '0;
`endif
        return r;
    endfunction

    // Model state per instance: layer start cycle and latched vector
    bit              active [2];
    int              t0 [2];
    logic [8*SZ-1:0] xl [2];
    int              nn [2];
    initial begin
        nn[0] = N0;
        nn[1] = N1;
        active[0] = 1'b0;
        active[1] = 1'b0;
        t0[0] = 0;
        t0[1] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) active[i] = 1'b0;
            else if (start && (!active[i] || (cyc - t0[i]) >= 11*nn[i] + 2)) begin
                active[i] = 1'b1;
                t0[i]     = cyc;
                xl[i]     = x_in;
            end
        end
        cyc = cyc + 1;
    end

    logic [1:0]    o_busy, o_done, o_rd, o_rv;
    logic [AW-1:0] o_addr [2];
    logic [7:0]    o_idx [2];
    logic [SZ-1:0] o_data [2];
    assign o_busy = {bus1.busy, bus0.busy};
    assign o_done = {bus1.done, bus0.done};
    assign o_rd   = {bus1.mem_rd, bus0.mem_rd};
    assign o_rv   = {bus1.res_valid, bus0.res_valid};
    assign o_addr[0] = bus0.mem_addr;
    assign o_addr[1] = bus1.mem_addr;
    assign o_idx[0]  = bus0.res_idx;
    assign o_idx[1]  = bus1.res_idx;
    assign o_data[0] = bus0.res_data;
    assign o_data[1] = bus1.res_data;

    // Per-cycle comparison against the schedule: LOAD of neuron n at rel 11n+1..11n+9, result at 11n+12
    always @(negedge clk) begin : compare
        int rel, r, n;
        bit e_busy, e_rd, e_rv, e_done;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                rel    = cyc - t0[i];
                r      = rel - 1;
                e_busy = active[i] && rel >= 1 && rel <= 11*nn[i] + 1;
                e_rd   = active[i] && r >= 0 && (r / 11) < nn[i] && (r % 11) <= 8;
                e_rv   = active[i] && rel >= 12 && (r % 11) == 0 && ((rel - 12) / 11) < nn[i];
                e_done = active[i] && rel == 11*nn[i] + 1;
                chk($sformatf("u%0d busy", i), 32'(o_busy[i]), 32'(e_busy));
                chk($sformatf("u%0d done", i), 32'(o_done[i]), 32'(e_done));
                chk($sformatf("u%0d mem_rd", i), 32'(o_rd[i]), 32'(e_rd));
                chk($sformatf("u%0d res_valid", i), 32'(o_rv[i]), 32'(e_rv));
                if (e_rd) chk($sformatf("u%0d mem_addr", i), 32'(o_addr[i]), 32'(9*(r/11) + r%11));
                if (e_rv) begin
                    n = (rel - 12) / 11;
                    chk($sformatf("u%0d res_idx", i), 32'(o_idx[i]), 32'(n));
                    chk($sformatf("u%0d res_data", i), 32'(o_data[i]), 32'(ref_res(xl[i], n)));
                end
            end
        end
    end

    ev_t log0[$];
    ev_t log1[$];
    int  dn0[$];
    int  dn1[$];
    always @(negedge clk) begin
        if (bus0.res_valid === 1'b1) log0.push_back('{cyc, bus0.res_data, bus0.res_idx});
        if (bus1.res_valid === 1'b1) log1.push_back('{cyc, bus1.res_data, bus1.res_idx});
        if (bus0.done === 1'b1) dn0.push_back(cyc);
        if (bus1.done === 1'b1) dn1.push_back(cyc);
    end

    task automatic clear_logs();
        log0.delete(); log1.delete(); dn0.delete(); dn1.delete();
    endtask

    // One-cycle start pulse; returns the start cycle number
    task automatic pulse_start(input logic [8*SZ-1:0] x, output int ts);
        @(posedge clk); #1;
        start = 1'b1;
        x_in  = x;
        ts    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        for (int g = 0; g < 500 && cyc < target; g++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (bus0.busy === 1'b0 && bus1.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle timeout", 32'(ok), 32'd1);
    endtask

    task automatic fill_std();
        for (int a = 0; a < 64; a++) mem[a] = '0;
        for (int n = 0; n < N0; n++) begin
            for (int k = 0; k < 8; k++) mem[9*n + k] = 16'd1;
            mem[9*n + 8] = 16'(10*n);
        end
    endtask

    int ts;
    logic [SZ-1:0] exp_neg;

    initial begin
        start = 1'b0;
        x_in  = '0;
        rst   = 1'b1;
        for (int a = 0; a < 64; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(bus0.busy), 32'd0);
        chk("rst mem_rd", 32'(bus0.mem_rd), 32'd0);
        chk("rst mem_addr", 32'(bus0.mem_addr), 32'd0);
        chk("rst res_idx", 32'(bus0.res_idx), 32'd0);
        chk("rst res_data", 32'(bus0.res_data), 32'd0);
        chk("rst pu_x", 32'(bus0.pu_x == '0), 32'd1);
        chk("rst pu_w", 32'(bus0.pu_w == '0), 32'd1);
        chk("rst pu_bias", 32'(bus0.pu_bias), 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single neuron: x=2, w=3, bias=5 -> 53
        for (int k = 0; k < 8; k++) mem[k] = 16'd3;
        mem[8] = 16'd5;
        clear_logs();
        pulse_start(rep(16'd2), ts);
        wait_idle();
        chk("single count", 32'(log1.size()), 32'd1);
        if (log1.size() > 0) begin
            chk("single data", 32'(log1[0].d), 32'd53);
            chk("single idx", 32'(log1[0].idx), 32'd0);
            chk("single latency", 32'(log1[0].c - ts), 32'd12);
        end
        chk("single done count", 32'(dn1.size()), 32'd1);
        if (dn1.size() > 0) chk("single done latency", 32'(dn1[0] - ts), 32'd12);

        // Four neurons with a rejected start in LOAD of neuron 1
        fill_std();
        clear_logs();
        pulse_start(rep(16'd1), ts);
        wait_cyc(ts + 14);
        start = 1'b1;
        x_in  = rep(16'd5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        chk("four count", 32'(log0.size()), 32'd4);
        for (int j = 0; j < 4 && j < log0.size(); j++) begin
            chk($sformatf("four data%0d", j), 32'(log0[j].d), 32'(8 + 10*j));
            chk($sformatf("four idx%0d", j), 32'(log0[j].idx), 32'(j));
            if (j > 0) chk($sformatf("four gap%0d", j), 32'(log0[j].c - log0[j-1].c), 32'd11);
        end
        chk("four done count", 32'(dn0.size()), 32'd1);

        // Reset in EVAL of neuron 2, then restart
        clear_logs();
        pulse_start(rep(16'd1), ts);
        wait_cyc(ts + 33);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(bus0.busy), 32'd0);
        chk("abort res_valid", 32'(bus0.res_valid), 32'd0);
        chk("abort done", 32'(bus0.done), 32'd0);
        chk("abort mem_rd", 32'(bus0.mem_rd), 32'd0);
        chk("abort results", 32'(log0.size()), 32'd2);
        clear_logs();
        pulse_start(rep(16'd1), ts);
        wait_idle();
        chk("restart count", 32'(log0.size()), 32'd4);
        if (log0.size() > 0) begin
            chk("restart idx0", 32'(log0[0].idx), 32'd0);
            chk("restart data0", 32'(log0[0].d), 32'd8);
        end

        // Negative result: x=1, w=-1, bias=0 -> 0xFFF8 (0 with ReLU)
`ifdef PU_SEQ_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hFFF8;
`endif
        for (int k = 0; k < 8; k++) mem[k] = 16'hFFFF;
        mem[8] = 16'h0000;
        clear_logs();
        pulse_start(rep(16'd1), ts);
        wait_idle();
        chk("neg count", 32'(log1.size()), 32'd1);
        if (log1.size() > 0) chk("neg data", 32'(log1[0].d), 32'(exp_neg));

        // Back-to-back layers, start the cycle after done
        for (int a = 0; a < 36; a++) mem[a] = 16'($urandom);
        clear_logs();
        pulse_start({$urandom, $urandom, $urandom, $urandom}, ts);
        wait_cyc(ts + 46);
        start = 1'b1;
        x_in  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        chk("b2b count", 32'(log0.size()), 32'd8);
        chk("b2b done count", 32'(dn0.size()), 32'd2);
        if (log0.size() == 8) chk("b2b idx restart", 32'(log0[4].idx), 32'd0);

        // Randomized layers with stray start pulses
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 36; a++) mem[a] = 16'($urandom);
            pulse_start({$urandom, $urandom, $urandom, $urandom}, ts);
            for (int c = 0; c < 50; c++) begin
                start = ($urandom_range(0, 3) == 0);
                x_in  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
            end
            start = 1'b0;
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
